// File: rtl/mdu_pkg.sv
// mdu_pkg: shared op encodings and FSM state constants
// for the iterative multiply/divide unit.
package mdu_pkg;

  localparam logic [1:0] MDU_MULTU = 2'b00;
  localparam logic [1:0] MDU_MULT  = 2'b01;
  localparam logic [1:0] MDU_DIVU  = 2'b10;
  localparam logic [1:0] MDU_DIV   = 2'b11;

  typedef logic [1:0] mdu_state_t;

  localparam mdu_state_t ST_IDLE = 2'd0;
  localparam mdu_state_t ST_CALC = 2'd1;
  localparam mdu_state_t ST_FIX  = 2'd2;

  function automatic logic op_is_div(
    input logic [1:0] op
  );
    return op[1];
  endfunction

  function automatic logic op_is_signed(
    input logic [1:0] op
  );
    return op[0];
  endfunction

endpackage

// File: rtl/mdu_if.sv
// mdu_if: request / HI-LO access bundle between
// the execute stage (master) and the mdu (slave).
interface mdu_if #(
  parameter int WIDTH = 32
) ();

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             cancel;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b,
    output hi_we, lo_we, wdata,
    output cancel,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b,
    input  hi_we, lo_we, wdata,
    input  cancel,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/mdu_step.sv
// mdu_step: one radix-2 iteration, either a shift-add
// multiply step or a restoring divide step.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   m,
  output logic [2*WIDTH-1:0] acc_nxt
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] diff;

  always_comb begin
    sum    = {1'b0, acc[2*WIDTH-1:WIDTH]}
           + (acc[0] ? {1'b0, m} : '0);
    rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff   = rem_sh - {1'b0, m};
    // diff[WIDTH] set means the trial subtract borrowed
    if (!is_div)
      acc_nxt = {sum, acc[WIDTH-1:1]};
    else if (!diff[WIDTH])
      acc_nxt = {diff[WIDTH-1:0],
                 acc[WIDTH-2:0], 1'b1};
    else
      acc_nxt = {rem_sh[WIDTH-1:0],
                 acc[WIDTH-2:0], 1'b0};
  end

endmodule

// File: rtl/mdu.sv
// mdu: iterative MULT/MULTU/DIV/DIVU unit with HI/LO,
// WIDTH+1 cycle latency, cancellable in flight.
module mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  rst,
  mdu_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mdu_state_t         state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] step_nxt;
  logic [WIDTH-1:0]   m_q;
  logic [WIDTH-1:0]   a_q;
  logic               div_q;
  logic               div0_q;
  logic               neg_q;
  logic               neg_r;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;

  logic               sgn;
  logic               is_div;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic               launch;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  always_comb begin
    sgn    = op_is_signed(bus.op);
    is_div = op_is_div(bus.op);
    a_neg  = sgn & bus.a[WIDTH-1];
    b_neg  = sgn & bus.b[WIDTH-1];
    a_mag  = a_neg ? -bus.a : bus.a;
    b_mag  = b_neg ? -bus.b : bus.b;
    launch = (state == ST_IDLE)
           & bus.start & ~bus.cancel;
  end

  mdu_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .is_div  (div_q),
    .acc     (acc),
    .m       (m_q),
    .acc_nxt (step_nxt)
  );

  // MIN/-1 needs no special case: -MIN wraps to MIN
  always_comb begin
    prod = neg_q ? -acc : acc;
    quot = neg_q ? -acc[WIDTH-1:0]
                 : acc[WIDTH-1:0];
    rem  = neg_r ? -acc[2*WIDTH-1:WIDTH]
                 : acc[2*WIDTH-1:WIDTH];
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (div_q && div0_q) begin
      res_hi = a_q;
      res_lo = '1;
    end else if (div_q) begin
      res_hi = rem;
      res_lo = quot;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      acc    <= '0;
      m_q    <= '0;
      a_q    <= '0;
      div_q  <= 1'b0;
      div0_q <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (1'b1)
        (state == ST_IDLE): begin
          if (bus.hi_we) hi_q <= bus.wdata;
          if (bus.lo_we) lo_q <= bus.wdata;
          if (launch) begin
            state  <= ST_CALC;
            cnt    <= '0;
            acc    <= is_div ? {{WIDTH{1'b0}}, a_mag}
                             : {{WIDTH{1'b0}}, b_mag};
            m_q    <= is_div ? b_mag : a_mag;
            a_q    <= bus.a;
            div_q  <= is_div;
            div0_q <= (bus.b == '0);
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
          end
        end
        (state == ST_CALC): begin
          if (bus.cancel) begin
            state <= ST_IDLE;
          end else begin
            acc <= step_nxt;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) state <= ST_FIX;
          end
        end
        (state == ST_FIX): begin
          state <= ST_IDLE;
          if (!bus.cancel) begin
            hi_q   <= res_hi;
            lo_q   <= res_lo;
            done_q <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy = (state != ST_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// tb_mdu: scoreboard bench for mdu (WIDTH=32),
// reference results from plain SV arithmetic.
module tb_mdu;
  import mdu_pkg::*;

  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  res_t sb_q[$];
  int   n_run  = 0;
  int   n_fail = 0;
  res_t r;

  always #5 clk = ~clk;

  mdu_if #(.WIDTH(W)) bus ();

  mdu #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic res_t model(
    input logic [1:0] op,
    input logic [W-1:0] a,
    input logic [W-1:0] b
  );
    res_t   m;
    longint pa, pb;
    int     sa, sb;
    m = '0;
    case (op)
      MDU_MULTU:
        {m.hi, m.lo} = {32'b0, a} * {32'b0, b};
      MDU_MULT: begin
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        {m.hi, m.lo} = pa * pb;
      end
      MDU_DIVU: begin
        if (b == 0) m = {a, 32'hFFFF_FFFF};
        else begin
          m.lo = a / b;
          m.hi = a % b;
        end
      end
      default: begin
        if (b == 0) m = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 &&
                 b == 32'hFFFF_FFFF)
          m = {32'h0, 32'h8000_0000};
        else begin
          sa = $signed(a);
          sb = $signed(b);
          m.lo = sa / sb;
          m.hi = sa % sb;
        end
      end
    endcase
    return m;
  endfunction

  task automatic launch(
    input logic [1:0] op,
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input bit now,
    input bit push
  );
    if (!now) @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    if (push) sb_q.push_back(model(op, a, b));
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(
    input string tag,
    input bit inject,
    output res_t got
  );
    int   cyc   = 1;
    int   nbusy = 0;
    bit   seen  = 0;
    res_t exp;
    while (!seen && cyc < 100) begin
      if (bus.busy) nbusy++;
      if (bus.done) seen = 1;
      else begin
        if (inject && cyc == 5) begin
          bus.start = 1'b1;
          bus.op    = MDU_DIVU;
          bus.a     = 32'd100;
          bus.b     = 32'd3;
          bus.hi_we = 1'b1;
          bus.lo_we = 1'b1;
          bus.wdata = 32'hDEAD;
        end else begin
          bus.start = 1'b0;
          bus.hi_we = 1'b0;
          bus.lo_we = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    check({tag, "_done"}, seen, 1);
    check({tag, "_lat"}, cyc, 34);
    check({tag, "_busy"}, nbusy, 33);
    check({tag, "_sb"}, sb_q.size() > 0, 1);
    if (seen && sb_q.size() > 0) begin
      exp = sb_q.pop_front();
      check({tag, "_hi"}, bus.hi, exp.hi);
      check({tag, "_lo"}, bus.lo, exp.lo);
    end
    got = {bus.hi, bus.lo};
  endtask

  initial begin
    bit any_done;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.a     = '0;
    bus.b     = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;
    bus.cancel = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_hi", bus.hi, 0);
    check("rst_lo", bus.lo, 0);
    rst = 1'b1;

    launch(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 0, 1);
    wait_done("multu", 0, r);
    check("multu_hi_k", r.hi, 32'h1);
    check("multu_lo_k", r.lo, 32'hFFFF_FFFE);

    launch(MDU_MULT, -32'sd3, 32'd5, 0, 1);
    wait_done("mult", 0, r);
    check("mult_hi_k", r.hi, 32'hFFFF_FFFF);
    check("mult_lo_k", r.lo, 32'hFFFF_FFF1);

    launch(MDU_DIV, -32'sd7, 32'd2, 0, 1);
    wait_done("div", 0, r);
    check("div_lo_k", r.lo, 32'hFFFF_FFFD);
    check("div_hi_k", r.hi, 32'hFFFF_FFFF);

    // next start issued in the done cycle
    launch(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 1);
    wait_done("ovf", 0, r);
    check("ovf_lo_k", r.lo, 32'h8000_0000);
    check("ovf_hi_k", r.hi, 32'h0);

    launch(MDU_DIVU, 32'd7, 32'd0, 0, 1);
    wait_done("divu0", 0, r);
    check("divu0_lo_k", r.lo, 32'hFFFF_FFFF);
    check("divu0_hi_k", r.hi, 32'h7);

    launch(MDU_DIV, -32'sd5, 32'd0, 0, 1);
    wait_done("div0s", 0, r);

    for (int i = 0; i < 10; i++) begin
      logic [1:0]   op;
      logic [W-1:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = (i % 3 == 0) ? W'($urandom_range(0, 5))
                        : $urandom;
      launch(op, a, b, 0, 1);
      wait_done("rand", 0, r);
    end

    @(negedge clk);
    bus.hi_we = 1'b1;
    bus.wdata = 32'h1234;
    @(negedge clk);
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b1;
    bus.wdata = 32'h5678;
    @(negedge clk);
    bus.lo_we = 1'b0;
    check("mthi", bus.hi, 32'h1234);
    check("mtlo", bus.lo, 32'h5678);

    launch(MDU_MULTU, 32'd3, 32'd4, 0, 0);
    repeat (9) @(negedge clk);
    bus.cancel = 1'b1;
    @(negedge clk);
    bus.cancel = 1'b0;
    check("cancel_busy", bus.busy, 0);
    any_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) any_done = 1;
    end
    check("cancel_nodone", any_done, 0);
    check("cancel_hi", bus.hi, 32'h1234);
    check("cancel_lo", bus.lo, 32'h5678);

    bus.start  = 1'b1;
    bus.cancel = 1'b1;
    bus.op     = MDU_MULTU;
    bus.a      = 32'd9;
    bus.b      = 32'd9;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    check("stcan_busy", bus.busy, 0);
    any_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) any_done = 1;
    end
    check("stcan_nodone", any_done, 0);
    check("stcan_lo", bus.lo, 32'h5678);

    launch(MDU_MULTU, 32'd6, 32'd7, 0, 1);
    wait_done("ignore", 1, r);
    check("ignore_lo_k", r.lo, 32'd42);
    check("ignore_hi_k", r.hi, 32'd0);

    launch(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_busy", bus.busy, 0);
    check("arst_done", bus.done, 0);
    check("arst_hi", bus.hi, 0);
    check("arst_lo", bus.lo, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_busy", bus.busy, 0);

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Parametrised iterative multiply/divide unit with architectural HI/LO registers, the next step for the multi-cycle datapath's execution stage beyond the single-cycle ALU. It executes MULT/MULTU/DIV/DIVU over WIDTH+1 cycles, serves MFHI/MFLO/MTHI/MTLO, and raises `busy` so the control FSM holds `PCWr`/`IRWr` until the result is ready. An interrupt flush (`cancel`) aborts an operation in flight without touching HI/LO.

## Interface
- `WIDTH`, 32: operand width and HI/LO width; must be ≥ 4.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request; operands and `op` are sampled on the same edge.
- `op`  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- `a`  in  WIDTH  multiplicand / dividend (rs).
- `b`  in  WIDTH  multiplier / divisor (rt).
- `hi_we`  in  1  MTHI write strobe.
- `lo_we`  in  1  MTLO write strobe.
- `wdata`  in  WIDTH  MTHI/MTLO data.
- `cancel`  in  1  abort the operation in flight (interrupt/eret flush).
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse: HI/LO hold the new result.
- `hi`  out  WIDTH  HI register (MFHI source).
- `lo`  out  WIDTH  LO register (MFLO source).

## Operation
- States: IDLE, CALC, FIX. Reset: state IDLE; `busy`=0, `done`=0, `hi`=0, `lo`=0, step counter 0.
- IDLE + `start` (and no `cancel`): latch operands, take magnitudes for signed ops, record result signs, go to CALC with counter 0.
- CALC: one radix-2 step per cycle. Multiply uses shift-add into a 2·WIDTH accumulator. Divide uses restoring division, one quotient bit per step. After WIDTH steps, go to FIX.
- FIX: apply sign correction and write HI/LO.
  - Multiply: HI = upper WIDTH bits, LO = lower WIDTH bits of the 2·WIDTH product.
  - Divide: LO = quotient, HI = remainder. Quotient sign is sign(a) XOR sign(b). Remainder takes the sign of the dividend (truncating division).
  - Then go to IDLE and pulse `done`.
- Divide by zero (`b`=0, signed or unsigned): LO = all ones, HI = `a` unchanged. Same latency as a normal divide.
- Signed overflow (DIV of most-negative value by −1): LO = most-negative value, HI = 0.
- `start` while `busy`: ignored. No restart, no effect on the running op.
- `hi_we`/`lo_we` in IDLE: register is written on the next edge. While `busy`, the strobes are ignored.
- `start` together with `hi_we`/`lo_we` in IDLE: the write is applied and the op is launched. The result overwrites HI/LO at FIX.
- `cancel` in CALC or FIX: go to IDLE on the next edge. HI/LO are unchanged and `done` is not pulsed. `cancel` in IDLE: no effect. `cancel` with `start`: cancel wins and no op starts.
- `rst` asserted mid-operation: immediate return to reset values.

## Timing
- `start` sampled at edge E0.
- `busy` is 1 from after E0 through E0+WIDTH+1 (WIDTH+1 cycles: WIDTH in CALC, 1 in FIX).
- HI/LO are updated at edge E0+WIDTH+1. `done`=1 and `busy`=0 during the following cycle.
- A new `start` is accepted in the same cycle `done` is high.
- `hi`/`lo` are direct register outputs, with no combinational path from inputs.
- `busy` and `done` are decoded from registered state only.

## Structure
- Package `mdu_pkg`: op encoding constants (`MDU_MULTU`, `MDU_MULT`, `MDU_DIVU`, `MDU_DIV`) and the state enum (IDLE/CALC/FIX).
- The step counter width is $clog2(WIDTH+1).
- One sub-module is natural: `mdu_step`, the combinational single-step shift-add / restore-subtract slice, instantiated once.
- The top module holds the FSM, counter, sign bookkeeping and HI/LO.

## Test plan
All scenarios use WIDTH=32.
- MULTU a=0xFFFFFFFF, b=2 → `done` 34 cycles after start; HI=0x00000001, LO=0xFFFFFFFE; `busy` high exactly 33 cycles.
- MULT a=−3, b=5 → HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIV a=−7, b=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIV a=0x80000000, b=0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU a=7, b=0 → LO=0xFFFFFFFF, HI=0x00000007, normal latency.
- Preload MTHI 0x1234 and MTLO 0x5678. Start MULTU, assert `cancel` in cycle 10 → idle next cycle, no `done`, HI/LO still 0x1234/0x5678. `start`+`cancel` together → no op.
- During `busy`: pulse `start` with new operands and pulse `hi_we` → both ignored; original result delivered. Assert `rst` mid-CALC → all outputs return to 0 immediately.
